// File: rtl/vproc_div_seq.sv
// Sequential SIMD integer divider for vector elements of 8, 16 or 32 bits.
// A request is latched in IDLE (or DONE on a back-to-back handshake). PREP
// takes magnitudes, CALC runs restoring division on all elements at once,
// FIX applies signs and the byte mask, and DONE holds the result until it
// is consumed.
// Optional feature: define VPROC_DIV_SEQ_EARLY_OUT_EN to go straight from
// PREP to FIX when every active element has a result that is known
// up front (zero divisor, signed overflow or zero dividend).
module vproc_div_seq #(
    parameter int unsigned DIV_OP_W       = 64,
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned TAG_W          = 8,
    parameter bit          DONT_CARE_ZERO = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,
    input  logic                  sync_rst_ni,

    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [TAG_W-1:0]      in_tag_i,
    input  logic [1:0]            in_eew_i,
    input  logic                  in_signed_i,
    input  logic                  in_rem_i,
    input  logic [DIV_OP_W-1:0]   in_op1_i,
    input  logic [DIV_OP_W-1:0]   in_op2_i,
    input  logic [DIV_OP_W/8-1:0] in_mask_i,

    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [TAG_W-1:0]      out_tag_o,
    output logic [DIV_OP_W-1:0]   out_res_o,
    output logic [DIV_OP_W/8-1:0] out_mask_o,

    output logic                  busy_o
);

    localparam int unsigned NB = DIV_OP_W / 8;
    localparam logic [DIV_OP_W-1:0] DC_VAL = DONT_CARE_ZERO ? '0 : 'x;

    typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

    state_e state_q, state_d;
    logic   accept;
    logic   early_out;

    // Latched request; op_a_q becomes |dividend| then the quotient, op_b_q
    // becomes |divisor|, rem_q is the partial remainder.
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic [1:0]          eew_q, eew_d;
    logic                signed_q, signed_d;
    logic                rem_sel_q, rem_sel_d;
    logic [NB-1:0]       mask_q, mask_d;
    logic [DIV_OP_W-1:0] op_a_q, op_a_d;
    logic [DIV_OP_W-1:0] op_b_q, op_b_d;
    logic [DIV_OP_W-1:0] rem_q, rem_d;
    logic [NB-1:0]       neg_a_q, neg_a_d;
    logic [NB-1:0]       neg_b_q, neg_b_d;
    logic [5:0]          cnt_q, cnt_d;
    logic [TAG_W-1:0]    out_tag_q, out_tag_d;
    logic [DIV_OP_W-1:0] out_res_q, out_res_d;
    logic [NB-1:0]       out_mask_q, out_mask_d;

    // Illegal eew 3 runs through the 32-bit datapath; its result is dropped.
    logic [1:0] w_sel;
    assign w_sel = (eew_q == 2'd3) ? 2'd2 : eew_q;

    // Per-width element results, selected by w_sel. Signs are kept per byte
    // (replicated across the element) so every width fills all NB bits.
    wire [2:0][DIV_OP_W-1:0] prep_a_w, prep_b_w, step_rem_w, step_quo_w, fix_res_w;
    wire [2:0][NB-1:0]       prep_na_w, prep_nb_w;
`ifdef VPROC_DIV_SEQ_EARLY_OUT_EN
    wire [2:0][NB-1:0]       triv_w;
    wire [2:0][DIV_OP_W-1:0] prep_eq_w, prep_er_w;
`endif

    for (genvar g = 0; g < 3; g++) begin : g_sew
        localparam int unsigned SEW = 8 << g;
        localparam int unsigned BPE = SEW / 8;
        for (genvar e = 0; e < DIV_OP_W / SEW; e++) begin : g_elem
            logic [SEW-1:0] a, b, r;
            logic           sign_a, sign_b, zero_b, neg_q;
            logic [SEW-1:0] abs_a, quo_fix, rem_fix;
            logic [SEW-1:0] step_r, step_q;
            logic [SEW:0]   step_t;
            logic           step_ge;

            assign a      = op_a_q[e*SEW +: SEW];
            assign b      = op_b_q[e*SEW +: SEW];
            assign r      = rem_q[e*SEW +: SEW];
            assign zero_b = (b == '0);

            // PREP: magnitudes and operand signs.
            assign sign_a = signed_q & a[SEW-1];
            assign sign_b = signed_q & b[SEW-1];
            assign abs_a  = sign_a ? -a : a;
            assign prep_a_w[g][e*SEW +: SEW]  = abs_a;
            assign prep_b_w[g][e*SEW +: SEW]  = sign_b ? -b : b;
            assign prep_na_w[g][e*BPE +: BPE] = {BPE{sign_a}};
            assign prep_nb_w[g][e*BPE +: BPE] = {BPE{sign_b}};

`ifdef VPROC_DIV_SEQ_EARLY_OUT_EN
            // Known results: x/0 gives all ones rem |x|; overflow and 0/y give
            // quotient |x| rem 0, i.e. what CALC would have left behind.
            assign triv_w[g][e*BPE +: BPE] = {BPE{
                ~(|mask_q[e*BPE +: BPE]) | zero_b | (a == '0) |
                (signed_q & (a == {1'b1, {(SEW-1){1'b0}}}) & (&b))}};
            assign prep_eq_w[g][e*SEW +: SEW] = zero_b ? '1 : abs_a;
            assign prep_er_w[g][e*SEW +: SEW] = zero_b ? abs_a : '0;
`endif

            // CALC: BITS_PER_CYCLE restoring steps; shifts a dividend bit into
            // the partial remainder and the quotient bit into the dividend LSB.
            always_comb begin
                step_r  = r;
                step_q  = a;
                step_t  = '0;
                step_ge = 1'b0;
                for (int s = 0; s < BITS_PER_CYCLE; s++) begin
                    step_t  = {step_r, step_q[SEW-1]};
                    step_ge = (step_t >= {1'b0, b});
                    step_r  = step_ge ? SEW'(step_t - {1'b0, b}) : step_t[SEW-1:0];
                    step_q  = {step_q[SEW-2:0], step_ge};
                end
            end
            assign step_rem_w[g][e*SEW +: SEW] = step_r;
            assign step_quo_w[g][e*SEW +: SEW] = step_q;

            // FIX: zero divisor forces all ones; otherwise negate on sign
            // mismatch. The remainder follows the dividend sign.
            assign neg_q   = neg_a_q[e*BPE] ^ neg_b_q[e*BPE];
            assign quo_fix = zero_b ? '1 : (neg_q ? -a : a);
            assign rem_fix = neg_a_q[e*BPE] ? -r : r;
            assign fix_res_w[g][e*SEW +: SEW] = rem_sel_q ? rem_fix : quo_fix;
        end
    end

`ifdef VPROC_DIV_SEQ_EARLY_OUT_EN
    assign early_out = (eew_q != 2'd3) && (&triv_w[w_sel]);
`else
    assign early_out = 1'b0;
`endif

    // FSM next state and handshake signals.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        state_d     = state_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    accept  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: state_d = early_out ? FIX : CALC;
            CALC: if (cnt_q == '0) state_d = FIX;
            FIX:  state_d = DONE;
            DONE: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (out_ready_i) begin
                    if (in_valid_i) begin
                        accept  = 1'b1;
                        state_d = PREP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: latch, prepare, iterate, fix.
    always_comb begin
        tag_d      = tag_q;
        eew_d      = eew_q;
        signed_d   = signed_q;
        rem_sel_d  = rem_sel_q;
        mask_d     = mask_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        rem_d      = rem_q;
        neg_a_d    = neg_a_q;
        neg_b_d    = neg_b_q;
        cnt_d      = cnt_q;
        out_tag_d  = out_tag_q;
        out_res_d  = out_res_q;
        out_mask_d = out_mask_q;
        if (accept) begin
            tag_d     = in_tag_i;
            eew_d     = in_eew_i;
            signed_d  = in_signed_i;
            rem_sel_d = in_rem_i;
            mask_d    = in_mask_i;
            op_a_d    = in_op1_i;
            op_b_d    = in_op2_i;
        end
        case (state_q)
            PREP: begin
                op_a_d  = prep_a_w[w_sel];
                op_b_d  = prep_b_w[w_sel];
                rem_d   = '0;
                neg_a_d = prep_na_w[w_sel];
                neg_b_d = prep_nb_w[w_sel];
                cnt_d   = 6'(((32'd8 << w_sel) / BITS_PER_CYCLE) - 32'd1);
`ifdef VPROC_DIV_SEQ_EARLY_OUT_EN
                if (early_out) begin
                    op_a_d = prep_eq_w[w_sel];
                    rem_d  = prep_er_w[w_sel];
                end
`endif
                if (eew_q == 2'd3) begin
                    op_a_d = DC_VAL;
                    op_b_d = DC_VAL;
                    rem_d  = DC_VAL;
                end
            end
            CALC: begin
                op_a_d = step_quo_w[w_sel];
                rem_d  = step_rem_w[w_sel];
                cnt_d  = cnt_q - 6'd1;
            end
            FIX: begin
                out_tag_d = tag_q;
                out_res_d = '0;
                if (eew_q != 2'd3) begin
                    for (int i = 0; i < NB; i++) begin
                        if (mask_q[i]) out_res_d[i*8 +: 8] = fix_res_w[w_sel][i*8 +: 8];
                    end
                end
                out_mask_d = (eew_q == 2'd3) ? '0 : mask_q;
            end
            default: ;
        endcase
    end

    // State register with asynchronous and synchronous clear.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        // NOTE: non-blocking assignments keep all flops updating on the same edge.
        if (!async_rst_ni) begin
            state_q <= IDLE;
        end else if (!sync_rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        // NOTE: datapath flops are reset as well so the outputs read 0 after reset.
        if (!async_rst_ni || !sync_rst_ni) begin
            tag_q      <= '0;
            eew_q      <= '0;
            signed_q   <= 1'b0;
            rem_sel_q  <= 1'b0;
            mask_q     <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            rem_q      <= '0;
            neg_a_q    <= '0;
            neg_b_q    <= '0;
            cnt_q      <= '0;
            out_tag_q  <= '0;
            out_res_q  <= '0;
            out_mask_q <= '0;
        end else begin
            tag_q      <= tag_d;
            eew_q      <= eew_d;
            signed_q   <= signed_d;
            rem_sel_q  <= rem_sel_d;
            mask_q     <= mask_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            rem_q      <= rem_d;
            neg_a_q    <= neg_a_d;
            neg_b_q    <= neg_b_d;
            cnt_q      <= cnt_d;
            out_tag_q  <= out_tag_d;
            out_res_q  <= out_res_d;
            out_mask_q <= out_mask_d;
        end
    end

    assign out_tag_o  = out_tag_q;
    assign out_res_o  = out_res_q;
    assign out_mask_o = out_mask_q;
    assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_vproc_div_seq.sv
// Directed bench for vproc_div_seq (DIV_OP_W=64, BITS_PER_CYCLE=1).
module tb_vproc_div_seq;

    localparam int W  = 64;
    localparam int NB = W / 8;
`ifdef VPROC_DIV_SEQ_EARLY_OUT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic          clk_i = 1'b0;
    logic          async_rst_ni = 1'b0;
    logic          sync_rst_ni = 1'b1;
    logic          in_valid_i = 1'b0;
    logic          in_ready_o;
    logic [7:0]    in_tag_i = '0;
    logic [1:0]    in_eew_i = '0;
    logic          in_signed_i = 1'b0;
    logic          in_rem_i = 1'b0;
    logic [W-1:0]  in_op1_i = '0;
    logic [W-1:0]  in_op2_i = '0;
    logic [NB-1:0] in_mask_i = '0;
    logic          out_valid_o;
    logic          out_ready_i = 1'b0;
    logic [7:0]    out_tag_o;
    logic [W-1:0]  out_res_o;
    logic [NB-1:0] out_mask_o;
    logic          busy_o;

    always #5 clk_i = ~clk_i;

    vproc_div_seq #(
        .DIV_OP_W(W), .BITS_PER_CYCLE(1), .TAG_W(8), .DONT_CARE_ZERO(1'b0)
    ) dut (
        .clk_i(clk_i), .async_rst_ni(async_rst_ni), .sync_rst_ni(sync_rst_ni),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_tag_i(in_tag_i),
        .in_eew_i(in_eew_i), .in_signed_i(in_signed_i), .in_rem_i(in_rem_i),
        .in_op1_i(in_op1_i), .in_op2_i(in_op2_i), .in_mask_i(in_mask_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_tag_o(out_tag_o),
        .out_res_o(out_res_o), .out_mask_o(out_mask_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic int lat_of(input int n, input bit trivial);
        return (EARLY && trivial) ? 3 : n + 3;
    endfunction

    // Present a request at a falling edge and return just after the accepting edge.
    task automatic start(input string name, input logic [7:0] tag, input logic [1:0] eew,
                         input logic sgn, input logic rem, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [NB-1:0] mask);
        int tries = 0;
        @(negedge clk_i);
        in_tag_i = tag; in_eew_i = eew; in_signed_i = sgn; in_rem_i = rem;
        in_op1_i = a; in_op2_i = b; in_mask_i = mask; in_valid_i = 1'b1;
        while (!in_ready_o && tries < 100) begin
            @(negedge clk_i);
            tries++;
        end
        check({name, "_in_ready"}, 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
    endtask

    // Count cycles after the accepting edge until out_valid_o is seen.
    task automatic wait_out(input string name, input int exp_lat);
        int lat = 0;
        do begin
            @(negedge clk_i);
            if (lat == 0) in_valid_i = 1'b0;
            lat++;
        end while (!out_valid_o && lat < 200);
        check({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    task automatic check_out(input string name, input logic [7:0] tag,
                             input logic [W-1:0] exp_res, input logic [NB-1:0] exp_mask);
        check({name, "_res"}, out_res_o, exp_res);
        check({name, "_mask"}, 64'(out_mask_o), 64'(exp_mask));
        check({name, "_tag"}, 64'(out_tag_o), 64'(tag));
    endtask

    task automatic consume(input string name);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        @(negedge clk_i);
        check({name, "_valid_drop"}, 64'(out_valid_o), 64'd0);
        check({name, "_idle_ready"}, 64'(in_ready_o), 64'd1);
    endtask

    task automatic run(input string name, input logic [7:0] tag, input logic [1:0] eew,
                       input logic sgn, input logic rem, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [NB-1:0] mask,
                       input logic [W-1:0] exp_res, input logic [NB-1:0] exp_mask,
                       input int exp_lat);
        start(name, tag, eew, sgn, rem, a, b, mask);
        wait_out(name, exp_lat);
        check_out(name, tag, exp_res, exp_mask);
        consume(name);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rises;
        // Reset state.
        repeat (2) @(negedge clk_i);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_valid", 64'(out_valid_o), 64'd0);
        async_rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        check("rst_res", out_res_o, 64'd0);
        check("rst_mask", 64'(out_mask_o), 64'd0);
        check("rst_tag", 64'(out_tag_o), 64'd0);

        // Unsigned 32-bit words.
        run("u32", 8'h11, 2'd2, 1'b0, 1'b0, 64'h00000064_FFFFFFFF, 64'h00000007_00000010,
            8'hFF, 64'h0000000E_0FFFFFFF, 8'hFF, lat_of(32, 1'b0));
        // Signed byte remainder: -7 rem 2 = -1.
        run("s8_rem", 8'h22, 2'd0, 1'b1, 1'b1, 64'hF9F9F9F9_F9F9F9F9, 64'h02020202_02020202,
            8'hFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, lat_of(8, 1'b0));
        // Signed words: 100/-7 and -100/7.
        run("s32_quo", 8'h33, 2'd2, 1'b1, 1'b0, 64'h00000064_FFFFFF9C, 64'hFFFFFFF9_00000007,
            8'hFF, 64'hFFFFFFF2_FFFFFFF2, 8'hFF, lat_of(32, 1'b0));
        run("s32_rem", 8'h34, 2'd2, 1'b1, 1'b1, 64'h00000064_FFFFFF9C, 64'hFFFFFFF9_00000007,
            8'hFF, 64'h00000002_FFFFFFFE, 8'hFF, lat_of(32, 1'b0));
        // Halfword overflow and divide by zero.
        run("s16_quo", 8'h44, 2'd1, 1'b1, 1'b0, 64'h80008000_80008000, 64'hFFFF0000_FFFF0000,
            8'hFF, 64'h8000FFFF_8000FFFF, 8'hFF, lat_of(16, 1'b1));
        run("s16_rem", 8'h45, 2'd1, 1'b1, 1'b1, 64'h80008000_80008000, 64'hFFFF0000_FFFF0000,
            8'hFF, 64'h00008000_00008000, 8'hFF, lat_of(16, 1'b1));
        // Unsigned byte divide by zero.
        run("u8_dz_quo", 8'h55, 2'd0, 1'b0, 1'b0, 64'h12121212_12121212, 64'h0,
            8'hFF, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, lat_of(8, 1'b1));
        run("u8_dz_rem", 8'h56, 2'd0, 1'b0, 1'b1, 64'h12121212_12121212, 64'h0,
            8'hFF, 64'h12121212_12121212, 8'hFF, lat_of(8, 1'b1));
        // Illegal element width.
        run("eew3", 8'h66, 2'd3, 1'b0, 1'b0, 64'h00000064_FFFFFFFF, 64'h00000007_00000010,
            8'hFF, 64'h0, 8'h00, 35);

        // Partial mask with output held back for 5 cycles.
        start("mask", 8'h77, 2'd2, 1'b0, 1'b0, 64'h00000064_FFFFFFFF, 64'h00000007_00000010, 8'h0F);
        wait_out("mask", lat_of(32, 1'b0));
        for (int i = 0; i < 5; i++) begin
            check_out("mask_hold", 8'h77, 64'h00000000_0FFFFFFF, 8'h0F);
            check("mask_hold_valid", 64'(out_valid_o), 64'd1);
            check("mask_hold_in_ready", 64'(in_ready_o), 64'd0);
            @(negedge clk_i);
        end
        consume("mask");

        // Back-to-back: next request taken on the DONE handshake edge.
        start("b2b_a", 8'h81, 2'd0, 1'b0, 1'b0, 64'h64646464_64646464, 64'h07070707_07070707, 8'hFF);
        wait_out("b2b_a", lat_of(8, 1'b0));
        check_out("b2b_a", 8'h81, 64'h0E0E0E0E_0E0E0E0E, 8'hFF);
        in_tag_i = 8'h82; in_eew_i = 2'd0; in_signed_i = 1'b0; in_rem_i = 1'b0;
        in_op1_i = 64'hFFFFFFFF_FFFFFFFF; in_op2_i = 64'h10101010_10101010; in_mask_i = 8'hFF;
        in_valid_i = 1'b1;
        out_ready_i = 1'b1;
        #1 check("b2b_in_ready", 64'(in_ready_o), 64'd1);
        @(posedge clk_i);
        #1 out_ready_i = 1'b0;
        wait_out("b2b_b", lat_of(8, 1'b0));
        check_out("b2b_b", 8'h82, 64'h0F0F0F0F_0F0F0F0F, 8'hFF);
        consume("b2b_b");

        // Asynchronous reset in CALC.
        start("arst", 8'h91, 2'd2, 1'b0, 1'b0, 64'h00000064_FFFFFFFF, 64'h00000007_00000010, 8'hFF);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (5) @(negedge clk_i);
        check("arst_busy_before", 64'(busy_o), 64'd1);
        async_rst_ni = 1'b0;
        #1;
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        async_rst_ni = 1'b1;
        #1;
        check("arst_in_ready", 64'(in_ready_o), 64'd1);
        check("arst_res", out_res_o, 64'd0);
        rises = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_i);
            if (out_valid_o) rises++;
        end
        check("arst_no_valid", 64'(rises), 64'd0);

        // Synchronous clear in CALC.
        start("srst", 8'hA1, 2'd1, 1'b0, 1'b0, 64'h00640064_00640064, 64'h00070007_00070007, 8'hFF);
        @(negedge clk_i);
        in_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        sync_rst_ni = 1'b0;
        #1 check("srst_busy_held", 64'(busy_o), 64'd1);
        @(negedge clk_i);
        sync_rst_ni = 1'b1;
        check("srst_busy", 64'(busy_o), 64'd0);
        check("srst_valid", 64'(out_valid_o), 64'd0);
        check("srst_in_ready", 64'(in_ready_o), 64'd1);

        // Still functional after the clear.
        run("post_rst", 8'hB1, 2'd1, 1'b0, 1'b0, 64'h00640064_00640064, 64'h00070007_00070007,
            8'hFF, 64'h000E000E_000E000E, 8'hFF, lat_of(16, 1'b0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vproc_div_seq.md
VPROC_DIV_SEQ -- requirements
Module: vproc_div_seq

Interface
- REQ-001 SHALL have parameter DIV_OP_W, default 64: operand width in bits; a multiple of 32.
- REQ-002 SHALL have parameter BITS_PER_CYCLE, default 1: quotient bits resolved per iteration; legal values 1 and 2.
- REQ-003 SHALL have parameter TAG_W, default 8: width of the opaque tag carried from input to output.
- REQ-004 SHALL have parameter DONT_CARE_ZERO, default 0: when 1, unused bits are 0 instead of X.
- REQ-005 SHALL use clock clk_i (input, 1 bit); the reset is async_rst_ni (input, 1 bit), asynchronous, active-low.
- REQ-006 sync_rst_ni  input  1  synchronous active-low clear.
- REQ-007 in_valid_i  input  1  request valid.
- REQ-008 in_ready_o  output  1  request accepted when high together with in_valid_i.
- REQ-009 in_tag_i  input  TAG_W  tag.
- REQ-010 in_eew_i  input  2  element width: 0=8, 1=16, 2=32 bits; 3 is illegal.
- REQ-011 in_signed_i  input  1  signed division.
- REQ-012 in_rem_i  input  1  return remainder instead of quotient.
- REQ-013 in_op1_i  input  DIV_OP_W  dividends.
- REQ-014 in_op2_i  input  DIV_OP_W  divisors.
- REQ-015 in_mask_i  input  DIV_OP_W/8  per-byte write mask.
- REQ-016 out_valid_o  output  1  result valid.
- REQ-017 out_ready_i  input  1  consumer ready.
- REQ-018 out_tag_o, out_res_o, out_mask_o  output  TAG_W, DIV_OP_W, DIV_OP_W/8  registered tag, results and mask.
- REQ-019 busy_o  output  1  high in every state other than IDLE.

Function
- REQ-020 SHALL implement an FSM with states IDLE, PREP, CALC, FIX and DONE.
- REQ-021 in_ready_o SHALL be high in IDLE, and high in DONE while out_ready_i is high; it SHALL be low in all other states.
- REQ-022 On an accepted request, the FSM SHALL latch all inputs and move to PREP.
- REQ-023 PREP (1 cycle) SHALL take the absolute values of signed operands and record the sign bits per element.
- REQ-024 CALC SHALL perform restoring division of all elements in parallel, resolving BITS_PER_CYCLE quotient bits per cycle, and SHALL last N = SEW/BITS_PER_CYCLE cycles, where SEW is the element width in bits (8, 16 or 32).
- REQ-025 FIX (1 cycle) SHALL apply signs: quotient negated when the two operand signs differ; remainder takes the sign of the dividend.
- REQ-026 out_valid_o SHALL rise exactly N+3 cycles after the accepting edge and SHALL stay high, with stable tag, result and mask, until out_ready_i is high.
- REQ-027 A handshake in DONE with a new valid request on the same edge SHALL move the FSM to PREP; without a new request it SHALL move to IDLE.
- REQ-028 Divide by zero SHALL produce quotient all ones and remainder equal to the dividend.
- REQ-029 Signed overflow (most-negative / -1) SHALL produce quotient equal to the dividend and remainder 0.
- REQ-030 For every byte whose mask bit is 0, out_res_o SHALL be 0; out_mask_o SHALL equal the latched in_mask_i.
- REQ-031 A request with in_eew_i = 3 SHALL be accepted and SHALL complete with the 32-bit latency, with out_res_o = 0 and out_mask_o = 0.

Reset
- REQ-032 While async_rst_ni is low, or on a clock edge with sync_rst_ni low, the FSM SHALL go to IDLE with out_valid_o=0 and busy_o=0.
- REQ-033 After reset, in_ready_o SHALL be 1; out_tag_o, out_res_o and out_mask_o SHALL be 0.
- REQ-034 A reset in any state SHALL discard the in-flight operation with no output handshake.

Configuration
- REQ-035 Macro VPROC_DIV_SEQ_EARLY_OUT_EN, when defined: if every element with any mask bit set is divide-by-zero, signed overflow, or has a zero dividend, the FSM SHALL go PREP->FIX, skipping CALC, so out_valid_o rises 3 cycles after acceptance.
- REQ-036 When VPROC_DIV_SEQ_EARLY_OUT_EN is undefined, CALC SHALL always last N cycles; results SHALL be identical in both builds.

Verification
- REQ-037 eew=2, unsigned, op1=0x00000064_FFFFFFFF, op2=0x00000007_00000010, mask all ones, BITS_PER_CYCLE=1 -> res=0x0000000E_0FFFFFFF, out_valid_o 35 cycles after acceptance.
- REQ-038 eew=0, signed, rem, all bytes op1=0xF9 (-7), op2=0x02 -> every byte 0xFF (-1), 11-cycle latency.
- REQ-039 eew=1, signed, op1 halfwords=0x8000, op2=0xFFFF -> quotient 0x8000; op2=0x0000 -> quotient 0xFFFF; same with rem -> remainder 0x0000 for 0x8000/0xFFFF and 0x8000 for 0x8000/0x0000.
- REQ-040 in_mask_i=0x0F, eew=2 -> upper word of out_res_o 0, out_mask_o=0x0F; out_ready_i held low 5 cycles -> outputs stable, in_ready_o low.
- REQ-041 Back-to-back: second request presented on the DONE handshake edge is accepted with no idle cycle; async reset asserted during CALC -> out_valid_o never rises, in_ready_o=1 after release.
- REQ-042 With VPROC_DIV_SEQ_EARLY_OUT_EN defined, all divisors 0 -> latency 3 cycles and results per REQ-028.
